// File: rtl/regfile_op_sequencer.sv
// Runs one {op, rd, rs1, rs2} command at a time on a 2R/1W register file: IDLE -> READ -> EXEC -> WRITE.
// Write/rsp three cycles after accept, one command per 4 cycles; REGSEQ_INIT_CLEAR_EN adds a post-reset zero-fill walk.
module regfile_op_sequencer #(
  parameter int DATA_W   = 8,
  parameter int ADDR_W   = 4,
  parameter int NUM_REGS = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [2:0]        cmd_op,
  input  logic [ADDR_W-1:0] cmd_rd,
  input  logic [ADDR_W-1:0] cmd_rs1,
  input  logic [ADDR_W-1:0] cmd_rs2,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_result,
  output logic [ADDR_W-1:0] reg1_read_addr,
  output logic [ADDR_W-1:0] reg2_read_addr,
  input  logic [DATA_W-1:0] reg1_read_data_in,
  input  logic [DATA_W-1:0] reg2_read_data_in,
  output logic [ADDR_W-1:0] reg_write_address_out,
  output logic [DATA_W-1:0] reg_write_data_out,
  output logic              reg_write_enable
);

  localparam logic [2:0] OP_ADD  = 3'b000;
  localparam logic [2:0] OP_SUB  = 3'b001;
  localparam logic [2:0] OP_AND  = 3'b010;
  localparam logic [2:0] OP_OR   = 3'b011;
  localparam logic [2:0] OP_XOR  = 3'b100;
  localparam logic [2:0] OP_PASS = 3'b101;
  localparam logic [2:0] OP_SHL1 = 3'b110;
  localparam logic [2:0] OP_NOP  = 3'b111;

  // A mis-sized instance never accepts a command rather than addressing phantom registers.
  localparam bit CFG_OK = (NUM_REGS == (1 << ADDR_W));

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_READ  = 3'd1,
    S_EXEC  = 3'd2,
    S_WRITE = 3'd3
`ifdef REGSEQ_INIT_CLEAR_EN
    , S_CLEAR = 3'd4
`endif
  } state_t;

  typedef struct packed {
    logic [2:0]        op;
    logic [ADDR_W-1:0] rd;
    logic [ADDR_W-1:0] rs1;
    logic [ADDR_W-1:0] rs2;
  } cmd_t;

`ifdef REGSEQ_INIT_CLEAR_EN
  localparam state_t RST_STATE = S_CLEAR;
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(NUM_REGS - 1);
  logic [ADDR_W-1:0] clr_addr;
`else
  localparam state_t RST_STATE = S_IDLE;
`endif

  state_t            state, state_nxt;
  cmd_t              cmd_q;
  logic [DATA_W-1:0] rs1_q, rs2_q;
  logic [DATA_W-1:0] result_q, rsp_q, alu_res;

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= RST_STATE;
      cmd_q    <= '0;
      rs1_q    <= '0;
      rs2_q    <= '0;
      result_q <= '0;
      rsp_q    <= '0;
`ifdef REGSEQ_INIT_CLEAR_EN
      clr_addr <= '0;
`endif
    end else begin
      state <= state_nxt;
      if (state == S_IDLE && cmd_valid && cmd_ready)
        cmd_q <= '{op: cmd_op, rd: cmd_rd, rs1: cmd_rs1, rs2: cmd_rs2};
      if (state == S_READ) begin
        rs1_q <= reg1_read_data_in;
        rs2_q <= reg2_read_data_in;
      end
      if (state == S_EXEC)
        result_q <= alu_res;
      if (state == S_WRITE)
        rsp_q <= result_q;
`ifdef REGSEQ_INIT_CLEAR_EN
      if (state == S_CLEAR)
        clr_addr <= clr_addr + 1'b1;
`endif
    end
  end

  always_comb begin
    alu_res = '0;
    case (cmd_q.op)
      OP_ADD:  alu_res = rs1_q + rs2_q;
      OP_SUB:  alu_res = rs1_q - rs2_q;
      OP_AND:  alu_res = rs1_q & rs2_q;
      OP_OR:   alu_res = rs1_q | rs2_q;
      OP_XOR:  alu_res = rs1_q ^ rs2_q;
      OP_PASS: alu_res = rs1_q;
      OP_SHL1: alu_res = {rs1_q[DATA_W-2:0], 1'b0};
      default: alu_res = '0;
    endcase
  end

  always_comb begin
    cmd_ready             = (state == S_IDLE) && CFG_OK;
    rsp_valid             = (state == S_WRITE);
    rsp_result            = (state == S_WRITE) ? result_q : rsp_q;
    reg1_read_addr        = cmd_q.rs1;
    reg2_read_addr        = cmd_q.rs2;
    reg_write_enable      = (state == S_WRITE) && (cmd_q.op != OP_NOP);
    reg_write_address_out = cmd_q.rd;
    reg_write_data_out    = result_q;
`ifdef REGSEQ_INIT_CLEAR_EN
    // Reset parks the FSM in CLEAR; hold off the write strobe until reset drops.
    if (state == S_CLEAR) begin
      reg_write_enable      = !reset;
      reg_write_address_out = clr_addr;
      reg_write_data_out    = '0;
    end
`endif

    state_nxt = state;
    case (state)
      S_IDLE:  if (cmd_valid && cmd_ready) state_nxt = S_READ;
      S_READ:  state_nxt = S_EXEC;
      S_EXEC:  state_nxt = S_WRITE;
      S_WRITE: state_nxt = S_IDLE;
`ifdef REGSEQ_INIT_CLEAR_EN
      S_CLEAR: if (clr_addr == LAST_ADDR) state_nxt = S_IDLE;
`endif
      default: state_nxt = S_IDLE;
    endcase
  end

endmodule
